// File: rtl/ysyx_ifq.sv
// Instruction fetch queue between IFU and IDU.
// Multi-lane compacting enqueue, single-entry dequeue, flush.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_ifq #(
    parameter int XLEN  = `YSYX_XLEN,
    parameter int DEPTH = 8,
    parameter int ENQ_W = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [ENQ_W-1:0]        in_valid,
    input  logic [32*ENQ_W-1:0]     in_inst,
    input  logic [XLEN*ENQ_W-1:0]   in_pc,
    input  logic [XLEN*ENQ_W-1:0]   in_pnpc,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [31:0]             out_inst,
    output logic [XLEN-1:0]         out_pc,
    output logic [XLEN-1:0]         out_pnpc,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (DEPTH < 2 * ENQ_W || (DEPTH & (DEPTH - 1)) != 0 ||
        !(ENQ_W == 1 || ENQ_W == 2 || ENQ_W == 4)) begin : g_bad_param
        $error("ysyx_ifq: illegal DEPTH/ENQ_W combination");
    end

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0]      inst_q [DEPTH];
    logic [XLEN-1:0]  pc_q   [DEPTH];
    logic [XLEN-1:0]  pnpc_q [DEPTH];

    logic [PTR_W-1:0] slot [ENQ_W];
    logic [CNT_W-1:0] k;
    logic             enq;
    logic             deq;

    // Each valid lane lands at tail plus the number of valid lanes below it.
    always_comb begin
        k = '0;
        for (int i = 0; i < ENQ_W; i++) begin
            slot[i] = tail_q + PTR_W'(k);
            k       = k + CNT_W'(in_valid[i]);
        end
    end

    assign in_ready  = count_q <= CNT_W'(DEPTH - ENQ_W);
    assign out_valid = count_q != '0;
    assign enq       = in_ready & (|in_valid) & ~flush;
    assign deq       = out_valid & out_ready & ~flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (deq) begin
                head_d = head_q + PTR_W'(1);
            end
            if (enq) begin
                tail_d = tail_q + PTR_W'(k);
            end
            count_d = count_q + (enq ? k : '0) - CNT_W'(deq);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            for (int i = 0; i < ENQ_W; i++) begin
                if (in_valid[i]) begin
                    inst_q[slot[i]] <= in_inst[32*i +: 32];
                    pc_q[slot[i]]   <= in_pc[XLEN*i +: XLEN];
                    pnpc_q[slot[i]] <= in_pnpc[XLEN*i +: XLEN];
                end
            end
        end
    end

    assign out_inst = inst_q[head_q];
    assign out_pc   = pc_q[head_q];
    assign out_pnpc = pnpc_q[head_q];
    assign count    = count_q;

`ifndef SYNTHESIS
    a_count_max: assert property (
        @(posedge clock) disable iff (reset)
        count_q <= CNT_W'(DEPTH));

    a_no_deq_empty: assert property (
        @(posedge clock) disable iff (reset)
        deq |-> (count_q != '0));

    a_ifu_hold: assert property (
        @(posedge clock) disable iff (reset)
        (!in_ready && (|in_valid) && !flush) |=>
        (in_valid == $past(in_valid) &&
         in_inst  == $past(in_inst)  &&
         in_pc    == $past(in_pc)    &&
         in_pnpc  == $past(in_pnpc)));
`endif

endmodule

// File: tb/tb_ysyx_ifq.sv
// Bench for ysyx_ifq: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_ysyx_ifq;

    localparam int XLEN  = 32;
    localparam int DEPTH = 8;
    localparam int ENQ_W = 2;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pnpc;
    } ent_t;

    logic        clock = 0;
    logic        reset;
    logic        flush;
    logic [1:0]  in_valid;
    logic [63:0] in_inst;
    logic [63:0] in_pc;
    logic [63:0] in_pnpc;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pnpc;
    logic        out_ready;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;
    ent_t q[$];
    bit stalled;

    ysyx_ifq #(.XLEN(XLEN), .DEPTH(DEPTH), .ENQ_W(ENQ_W)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_inst(in_inst),
        .in_pc(in_pc), .in_pnpc(in_pnpc),
        .in_ready(in_ready), .out_valid(out_valid),
        .out_inst(out_inst), .out_pc(out_pc), .out_pnpc(out_pnpc),
        .out_ready(out_ready), .count(count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic grp(input logic [1:0] v, input logic [31:0] pc0,
                       input logic [31:0] pc1);
        in_valid = v;
        in_pc    = {pc1, pc0};
        in_inst  = {pc1 ^ 32'h0000_0013, pc0 ^ 32'h0000_0013};
        in_pnpc  = {pc1 + 32'd4, pc0 + 32'd4};
    endtask

    // One clock: decide fire conditions from model occupancy, then apply.
    task automatic tick();
        bit rdy, enq, deq;
        ent_t e;
        rdy = (DEPTH - q.size()) >= ENQ_W;
        enq = rdy && (|in_valid) && !flush;
        deq = (q.size() != 0) && out_ready && !flush;
        stalled = !rdy && (|in_valid) && !flush;
        @(posedge clock);
        if (flush) begin
            q.delete();
        end else begin
            if (deq) void'(q.pop_front());
            if (enq) begin
                for (int i = 0; i < ENQ_W; i++) begin
                    if (in_valid[i]) begin
                        e.inst = in_inst[32*i +: 32];
                        e.pc   = in_pc[32*i +: 32];
                        e.pnpc = in_pnpc[32*i +: 32];
                        q.push_back(e);
                    end
                end
            end
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_count"}, count, q.size());
        chk({tag, "_out_valid"}, out_valid, q.size() != 0);
        chk({tag, "_in_ready"}, in_ready, (DEPTH - q.size()) >= ENQ_W);
        if (q.size() != 0) begin
            chk({tag, "_out_pc"}, out_pc, q[0].pc);
            chk({tag, "_out_inst"}, out_inst, q[0].inst);
            chk({tag, "_out_pnpc"}, out_pnpc, q[0].pnpc);
        end
    endtask

    initial begin
        reset = 1; flush = 0; out_ready = 0;
        grp(2'b00, 0, 0);
        #1;
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clock); #2; reset = 0;
        @(posedge clock); #1;

        // Basic two-lane enqueue then drain
        grp(2'b11, 32'h8000_0000, 32'h8000_0004);
        tick(); grp(2'b00, 0, 0);
        check_model("basic");
        chk("basic_cnt2", count, 2);
        chk("basic_pc0", out_pc, 32'h8000_0000);
        out_ready = 1;
        tick(); check_model("basic_d1");
        chk("basic_pc1", out_pc, 32'h8000_0004);
        tick(); check_model("basic_d2");
        chk("basic_empty", out_valid, 0);
        out_ready = 0;

        // Fill, hold a fifth group, then drain to reopen
        for (int g = 0; g < 4; g++) begin
            grp(2'b11, 32'h8000_1000 + 8 * g, 32'h8000_1004 + 8 * g);
            tick(); check_model("fill");
        end
        chk("full_cnt", count, 8);
        chk("full_rdy", in_ready, 0);
        grp(2'b11, 32'h8000_2000, 32'h8000_2004);
        tick(); check_model("full_hold");
        chk("full_hold_cnt", count, 8);
        out_ready = 1;
        tick(); check_model("full_d1");
        chk("full_d1_cnt", count, 7);
        chk("full_d1_rdy", in_ready, 0);
        tick(); check_model("full_d2");
        chk("full_d2_cnt", count, 6);
        chk("full_d2_rdy", in_ready, 1);
        out_ready = 0;
        tick(); check_model("full_acc");
        grp(2'b00, 0, 0);
        flush = 1; tick(); flush = 0;
        check_model("flush1");

        // Compaction of lane 1 into slot 0
        grp(2'b10, 32'h0, 32'h8000_0010);
        tick(); grp(2'b00, 0, 0);
        check_model("compact");
        chk("compact_cnt", count, 1);
        chk("compact_pc", out_pc, 32'h8000_0010);
        flush = 1; tick(); flush = 0;

        // Walk pointers to 7 and then write across the wrap
        for (int n = 0; n < 7; n++) begin
            grp(2'b01, 32'h8000_3000 + 4 * n, 0);
            tick(); grp(2'b00, 0, 0);
            out_ready = 1; tick(); out_ready = 0;
            check_model("walk");
        end
        grp(2'b11, 32'h0000_00A0, 32'h0000_00A4);
        tick(); grp(2'b00, 0, 0);
        check_model("wrap");
        chk("wrap_pc0", out_pc, 32'h0000_00A0);
        out_ready = 1;
        tick(); check_model("wrap_d1");
        chk("wrap_pc1", out_pc, 32'h0000_00A4);
        tick(); check_model("wrap_d2");
        out_ready = 0;

        // Simultaneous enqueue/dequeue at count 5, then flush beats both
        grp(2'b11, 32'h8000_4000, 32'h8000_4004); tick();
        grp(2'b11, 32'h8000_4008, 32'h8000_400C); tick();
        grp(2'b01, 32'h8000_4010, 0); tick();
        check_model("sim5");
        chk("sim5_cnt", count, 5);
        grp(2'b11, 32'h8000_4014, 32'h8000_4018); out_ready = 1;
        tick(); check_model("sim6");
        chk("sim6_cnt", count, 6);
        flush = 1; tick(); flush = 0;
        grp(2'b00, 0, 0); out_ready = 0;
        check_model("simfl");
        chk("simfl_cnt", count, 0);
        chk("simfl_valid", out_valid, 0);
        chk("simfl_rdy", in_ready, 1);

        // Asynchronous reset between edges
        for (int g = 0; g < 3; g++) begin
            grp(2'b11, 32'h8000_5000 + 8 * g, 32'h8000_5004 + 8 * g);
            tick();
        end
        grp(2'b00, 0, 0);
        check_model("pre_rst");
        #2 reset = 1;
        #1;
        q.delete();
        chk("arst_count", count, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_rdy", in_ready, 1);
        @(posedge clock); #2 reset = 0;
        @(posedge clock); #1;
        grp(2'b01, 32'h8000_0000, 0);
        tick(); grp(2'b00, 0, 0);
        check_model("post_rst");
        chk("post_rst_pc", out_pc, 32'h8000_0000);

        // Random traffic; a stalled group is held until accepted
        stalled = 0;
        for (int n = 0; n < 400; n++) begin
            if (!stalled) begin
                in_valid = 2'($urandom_range(0, 3));
                in_inst  = {$urandom, $urandom};
                in_pc    = {$urandom, $urandom};
                in_pnpc  = {$urandom, $urandom};
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            tick();
            check_model("rand");
        end
        flush = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
